// File: rtl/mux_4to1_pkg.sv
// Shared constants and select type for the registered 4-to-1 lane mux.
package mux_4to1_pkg;

  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_L0 = 2'd0;
  localparam sel_t SEL_L1 = 2'd1;
  localparam sel_t SEL_L2 = 2'd2;
  localparam sel_t SEL_L3 = 2'd3;

endpackage

// File: rtl/mux_4to1.sv
// Registered 4-to-1 mux: sel picks one WIDTH-bit lane of the packed input bus.
// Define MUX_4TO1_PARITY_EN to add c_par, the registered even parity of c.
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
`ifdef MUX_4TO1_PARITY_EN
  output logic                    c_par,
`endif
  output logic [WIDTH-1:0]        c
);

  logic [WIDTH-1:0] lane_sel;

  always_comb begin
    lane_sel = in[0 +: WIDTH];
    case (sel)
      SEL_L0: lane_sel = in[0*WIDTH +: WIDTH];
      SEL_L1: lane_sel = in[1*WIDTH +: WIDTH];
      SEL_L2: lane_sel = in[2*WIDTH +: WIDTH];
      SEL_L3: lane_sel = in[3*WIDTH +: WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
    end else begin
      c <= lane_sel;
    end
  end

`ifdef MUX_4TO1_PARITY_EN
  // Parity is taken from the same combinational lane so it lands with c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_par <= 1'b0;
    end else begin
      c_par <= ^lane_sel;
    end
  end
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: one WIDTH=1 and one WIDTH=8 instance share clk/rst_n.
module tb_mux_4to1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in1;
  logic [1:0]  sel1;
  logic [0:0]  c1;
  logic [31:0] in8;
  logic [1:0]  sel8;
  logic [7:0]  c8;
`ifdef MUX_4TO1_PARITY_EN
  logic        c_par1;
  logic        c_par8;
`endif

  int n_vec;
  int n_miss;

  mux_4to1 #(.WIDTH(1)) u_mux1 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in1),
    .sel   (sel1),
`ifdef MUX_4TO1_PARITY_EN
    .c_par (c_par1),
`endif
    .c     (c1)
  );

  mux_4to1 #(.WIDTH(8)) u_mux8 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in8),
    .sel   (sel8),
`ifdef MUX_4TO1_PARITY_EN
    .c_par (c_par8),
`endif
    .c     (c8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b1;
    in1    = 4'hF;
    sel1   = 2'd3;
    in8    = 32'hDDCCBBAA;
    sel8   = 2'd3;

    // async reset before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_c1", {31'd0, c1}, 32'h0);
    chk("rst_async_c8", {24'd0, c8}, 32'h0);
    tick();
    chk("rst_hold_c1", {31'd0, c1}, 32'h0);
    tick();
    rst_n = 1'b1;
    chk("rst_rel_pre_edge", {31'd0, c1}, 32'h0);
    tick();
    chk("rst_rel_c1", {31'd0, c1}, 32'h1);
    chk("rst_rel_c8", {24'd0, c8}, 32'hDD);

    // exhaustive WIDTH=1
    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 16; v++) begin
        logic [3:0] vec;
        vec  = v[3:0];
        in1  = vec;
        sel1 = s[1:0];
        tick();
        chk($sformatf("exh_s%0d_in%h", s, vec), {31'd0, c1}, {31'd0, vec[s]});
      end
    end

    // sel=2 directed pair
    sel1 = 2'd2;
    in1  = 4'b0100;
    tick();
    chk("sel2_0100", {31'd0, c1}, 32'h1);
    in1 = 4'b1011;
    tick();
    chk("sel2_1011", {31'd0, c1}, 32'h0);

    // WIDTH=8 lanes with latency check
    in8  = 32'hDDCCBBAA;
    sel8 = 2'd1;
    tick();
    chk("w8_sel1", {24'd0, c8}, 32'hBB);
    sel8 = 2'd3;
    #2;
    chk("w8_latency_hold", {24'd0, c8}, 32'hBB);
    tick();
    chk("w8_sel3", {24'd0, c8}, 32'hDD);
    sel8 = 2'd0;
    tick();
    chk("w8_sel0", {24'd0, c8}, 32'hAA);
    sel8 = 2'd2;
    in8  = 32'h11223344;
    tick();
    chk("w8_sel2_newin", {24'd0, c8}, 32'h22);

    // mid-stream reset
    sel1 = 2'd2;
    in1  = 4'b0100;
    tick();
    chk("mid_pre_c1", {31'd0, c1}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_c1", {31'd0, c1}, 32'h0);
    chk("mid_async_c8", {24'd0, c8}, 32'h0);
    tick();
    chk("mid_hold_c1", {31'd0, c1}, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("mid_resume_c1", {31'd0, c1}, 32'h1);
    chk("mid_resume_c8", {24'd0, c8}, 32'h22);

`ifdef MUX_4TO1_PARITY_EN
    in8  = 32'h00070000;
    sel8 = 2'd2;
    in1  = 4'b0010;
    sel1 = 2'd1;
    tick();
    chk("par_c8_07", {24'd0, c8}, 32'h07);
    chk("par_p8_07", {31'd0, c_par8}, 32'h1);
    chk("par_p1_1", {31'd0, c_par1}, 32'h1);
    sel8 = 2'd0;
    sel1 = 2'd0;
    tick();
    chk("par_c8_00", {24'd0, c8}, 32'h00);
    chk("par_p8_00", {31'd0, c_par8}, 32'h0);
    chk("par_p1_0", {31'd0, c_par1}, 32'h0);
    in8  = 32'h00000003;
    tick();
    chk("par_p8_03", {31'd0, c_par8}, 32'h0);
    in8  = 32'h000000FE;
    tick();
    chk("par_p8_fe", {31'd0, c_par8}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("par_rst", {31'd0, c_par8}, 32'h0);
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
